nes_fb_ctrl: RTL

Write-port controller for the NES framebuffer pair in the `clk_nes` domain. It arbitrates the single framebuffer write port between three requesters, in fixed priority: the PPU pixel stream, a fill-clear engine, and an OSD overlay writer. It also owns double-buffer selection, flipping the displayed buffer at end of frame. It sits between the PPU pixel-edge detector and the framebuffer RAMs; the display side reads `front_buf` through its own synchronizer.

---
 rtl/nes_fb_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/nes_fb_ctrl.sv
// Framebuffer write-port controller for the NES framebuffer pair.
// One write port is shared by three requesters in fixed priority: the PPU
// pixel stream, the fill-clear engine and the OSD overlay writer. The block
// also owns double-buffer selection and flips the displayed buffer at the
// end of each frame. A swap is deferred while a clear is filling the buffer
// that would become visible.
//
// OSD handshake: the requester holds osd_req, osd_addr, osd_data and osd_buf
// stable until it sees osd_ack, which is high for exactly one cycle and
// coincides with the framebuffer write that carries the item. After the ack
// it may drop osd_req or present the next item in the same cycle. A request
// is not eligible in the cycle its ack is shown, so at most one OSD write
// happens every two cycles.
module nes_fb_ctrl #(
    parameter int ACTIVE_LINES = 240,
    parameter bit DOUBLE_BUF   = 1'b1
) (
    input  logic        clk_nes,
    input  logic        rst_nes,
    input  logic        ppu_we,
    input  logic [15:0] ppu_addr,
    input  logic [5:0]  ppu_data,
    input  logic        ppu_frame_end,
    input  logic        freeze,
    input  logic        clr_start,
    input  logic [5:0]  clr_color,
    input  logic        clr_buf,
    output logic        clr_busy,
    input  logic        osd_req,
    input  logic [15:0] osd_addr,
    input  logic [5:0]  osd_data,
    input  logic        osd_buf,
    output logic        osd_ack,
    output logic        fb_we,
    output logic [15:0] fb_waddr,
    output logic [5:0]  fb_wdata,
    output logic        fb_wsel,
    output logic        front_buf,
    output logic        swap_pulse,
    output logic        dbg_state
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    // Address of the final clear write: last visible line, column 255.
    localparam logic [7:0]  LAST_LINE = 8'(ACTIVE_LINES - 1);
    localparam logic [15:0] LAST_ADDR = {LAST_LINE, 8'hFF};

    clr_state_t  state;
    logic [15:0] cnt;
    logic [5:0]  clr_color_q;
    logic        clr_buf_q;
    logic        swap_pending;

    logic        back_buf;
    logic        clr_tgt;
    logic        osd_tgt;
    logic        ppu_go;
    logic        clr_go;
    logic        osd_go;
    logic        swap_req;
    logic        swap_blocked;
    logic        swap_now;
    logic        set_pending;

    assign dbg_state = state;

    // Buffer targets; single-buffer mode funnels every write into buffer 0.
    assign back_buf = DOUBLE_BUF ? ~front_buf : 1'b0;
    assign clr_tgt  = DOUBLE_BUF ? clr_buf_q  : 1'b0;
    assign osd_tgt  = DOUBLE_BUF ? osd_buf    : 1'b0;

    // Fixed-priority grant: PPU, then clear, then OSD. Losers retry next cycle.
    assign ppu_go = ppu_we && !freeze;
    assign clr_go = (state == CLEAR) && !ppu_go;
    assign osd_go = osd_req && !osd_ack && !ppu_go && (state != CLEAR);

    // Swap decision: defer while the clear is filling the buffer about to be shown.
    // A pending swap absorbs any further frame_end and runs once the clear is done.
    assign swap_req     = ppu_frame_end && !freeze;
    assign swap_blocked = (state == CLEAR) && (clr_tgt == back_buf);
    assign swap_now     = swap_pending ? (state == IDLE) : (swap_req && !swap_blocked);
    assign set_pending  = !swap_pending && swap_req && swap_blocked;

    // Clear engine FSM: sweeps {line, column} over the visible area, one write per grant.
    always_ff @(posedge clk_nes or posedge rst_nes) begin
        if (rst_nes) begin
            state       <= IDLE;
            cnt         <= 16'd0;
            clr_color_q <= 6'd0;
            clr_buf_q   <= 1'b0;
            clr_busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_start) begin
                        state       <= CLEAR;
                        cnt         <= 16'd0;
                        clr_color_q <= clr_color;
                        clr_buf_q   <= clr_buf;
                        clr_busy    <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (clr_go) begin
                        cnt <= cnt + 16'd1;
                        if (cnt == LAST_ADDR) begin
                            state    <= IDLE;
                            clr_busy <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    clr_busy <= 1'b0;
                end
            endcase
        end
    end

    // Write port register: the granted requester's write appears one cycle later.
    always_ff @(posedge clk_nes or posedge rst_nes) begin
        if (rst_nes) begin
            fb_we    <= 1'b0;
            fb_waddr <= 16'd0;
            fb_wdata <= 6'd0;
            fb_wsel  <= 1'b0;
            osd_ack  <= 1'b0;
        end else begin
            fb_we   <= ppu_go || clr_go || osd_go;
            osd_ack <= osd_go;
            if (ppu_go) begin
                fb_waddr <= ppu_addr;
                fb_wdata <= ppu_data;
                fb_wsel  <= back_buf;
            end else if (clr_go) begin
                fb_waddr <= cnt;
                fb_wdata <= clr_color_q;
                fb_wsel  <= clr_tgt;
            end else if (osd_go) begin
                fb_waddr <= osd_addr;
                fb_wdata <= osd_data;
                fb_wsel  <= osd_tgt;
            end
        end
    end

    // Buffer flip and swap pulse; pending swaps are tracked until the clear finishes.
    always_ff @(posedge clk_nes or posedge rst_nes) begin
        if (rst_nes) begin
            front_buf    <= 1'b0;
            swap_pulse   <= 1'b0;
            swap_pending <= 1'b0;
        end else begin
            swap_pulse <= swap_now;
            if (swap_now && DOUBLE_BUF) begin
                front_buf <= ~front_buf;
            end
            if (swap_now) begin
                swap_pending <= 1'b0;
            end else if (set_pending) begin
                swap_pending <= 1'b1;
            end
        end
    end

endmodule
